// File: rtl/float_minmax_seq.sv
// Streaming frame min/max finder for 16-bit floats (1 sign, 4 exp bias 7, 11 frac), sharing one comparator.
// Optional FMM_INDEX_EN adds m_max_idx/m_min_idx outputs with the 0-based position of each extreme.

module float_comp (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [2:0]  aopb
);
  // Sign-magnitude ordering on raw bits: +0 ranks above -0 and NaN patterns order by magnitude.
  always_comb begin
    if (a == b)
      aopb = 3'b010;
    else if (a[15] != b[15])
      aopb = a[15] ? 3'b001 : 3'b100;
    else if ((a[14:0] > b[14:0]) ^ a[15])
      aopb = 3'b100;
    else
      aopb = 3'b001;
  end
endmodule

module float_minmax_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_max,
  output logic [15:0]      m_min,
  output logic [CNT_W-1:0] m_count,
  output logic             m_ovf,
  output logic             busy
`ifdef FMM_INDEX_EN
  ,
  output logic [CNT_W-1:0] m_max_idx,
  output logic [CNT_W-1:0] m_min_idx
`endif
);

  typedef enum logic [1:0] {ACCEPT, CMP_MAX, CMP_MIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_nxt;
  logic               first_q, last_q, ovf_q;
  logic [15:0]        x_q, max_q, min_q, cmp_b;
  logic [CNT_W-1:0]   count_q;
  logic [2:0]         aopb;
`ifdef FMM_INDEX_EN
  logic [CNT_W-1:0]   x_idx_q, max_idx_q, min_idx_q;
`endif

  float_comp u_comp (
    .a    (x_q),
    .b    (cmp_b),
    .aopb (aopb)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    cmp_b     = max_q;
    case (state)
      ACCEPT: begin
        s_ready = 1'b1;
        if (s_valid)
          state_nxt = first_q ? (s_last ? DONE : ACCEPT) : CMP_MAX;
      end
      CMP_MAX: state_nxt = CMP_MIN;
      CMP_MIN: begin
        cmp_b     = min_q;
        state_nxt = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCEPT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      x_q     <= '0;
      max_q   <= '0;
      min_q   <= '0;
      count_q <= '0;
`ifdef FMM_INDEX_EN
      x_idx_q   <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      case (state)
        ACCEPT: if (s_valid) begin
          x_q    <= s_data;
          last_q <= s_last;
          if (count_q == CNT_MAX) ovf_q   <= 1'b1;
          else                    count_q <= count_q + 1'b1;
`ifdef FMM_INDEX_EN
          x_idx_q <= count_q;
`endif
          if (first_q) begin
            max_q   <= s_data;
            min_q   <= s_data;
            first_q <= 1'b0;
`ifdef FMM_INDEX_EN
            max_idx_q <= '0;
            min_idx_q <= '0;
`endif
          end
        end
        // Strict compares only: a tie leaves the earlier element in place.
        CMP_MAX: if (aopb == 3'b100) begin
          max_q <= x_q;
`ifdef FMM_INDEX_EN
          max_idx_q <= x_idx_q;
`endif
        end
        CMP_MIN: if (aopb == 3'b001) begin
          min_q <= x_q;
`ifdef FMM_INDEX_EN
          min_idx_q <= x_idx_q;
`endif
        end
        DONE: if (m_ready) begin
          first_q <= 1'b1;
          count_q <= '0;
          ovf_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign m_max   = max_q;
  assign m_min   = min_q;
  assign m_count = count_q;
  assign m_ovf   = ovf_q;
  assign busy    = (state != ACCEPT) || !first_q;
`ifdef FMM_INDEX_EN
  assign m_max_idx = max_idx_q;
  assign m_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_float_minmax_seq.sv
// Scoreboard bench for float_minmax_seq: directed frames plus random frames against a value-ordering model.
module tb_float_minmax_seq;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [15:0]      s_data = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [15:0]      m_max, m_min;
  logic [CNT_W-1:0] m_count;
  logic             m_ovf, busy;
`ifdef FMM_INDEX_EN
  logic [CNT_W-1:0] m_max_idx, m_min_idx;
`endif

  float_minmax_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_max(m_max), .m_min(m_min), .m_count(m_count), .m_ovf(m_ovf), .busy(busy)
`ifdef FMM_INDEX_EN
    , .m_max_idx(m_max_idx), .m_min_idx(m_min_idx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mx;
    logic [15:0] mn;
    int          cnt;
    bit          ovf;
    int          mxi;
    int          mni;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   hold   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed value rank: larger rank means larger float; -0 is never generated randomly.
  function automatic int fkey(input logic [15:0] d);
    int mag;
    mag = int'(d[14:0]);
    return d[15] ? -mag : mag;
  endfunction

  function automatic exp_t model(input logic [15:0] fr[$]);
    exp_t e;
    e.mx = fr[0]; e.mn = fr[0]; e.mxi = 0; e.mni = 0;
    for (int i = 1; i < fr.size(); i++) begin
      if (fkey(fr[i]) > fkey(e.mx)) begin e.mx = fr[i]; e.mxi = (i > CMAX) ? CMAX : i; end
      if (fkey(fr[i]) < fkey(e.mn)) begin e.mn = fr[i]; e.mni = (i > CMAX) ? CMAX : i; end
    end
    e.cnt = (fr.size() > CMAX) ? CMAX : fr.size();
    e.ovf = fr.size() > CMAX;
    return e;
  endfunction

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    logic [15:0] pool [4];
    pool[0] = 16'h4700; pool[1] = 16'hc700; pool[2] = 16'h0000; pool[3] = 16'h3800;
    if ($urandom_range(0, 9) < 3) return pool[$urandom_range(0, 3)];
    v = 16'($urandom);
    if (v == 16'h8000) v = 16'h0000;
    return v;
  endfunction

  // Downstream ready: random unless a test is holding it low.
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every result handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && m_valid) begin
      check("s_ready_while_valid", s_ready, 0);
      if (m_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_result: got max 0x%0h with empty scoreboard", m_max);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("m_max", m_max, e.mx);
          check("m_min", m_min, e.mn);
          check("m_count", m_count, e.cnt);
          check("m_ovf", m_ovf, e.ovf);
`ifdef FMM_INDEX_EN
          check("m_max_idx", m_max_idx, e.mxi);
          check("m_min_idx", m_min_idx, e.mni);
`endif
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] d, input bit l);
    int w = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && w < 2000) begin @(negedge clk); w++; end
    if (!s_ready) begin
      n_vec++; n_fail++;
      $display("FAIL send_timeout: s_ready stayed 0, required 1");
    end
    @(negedge clk);
    s_valid = 1'b0; s_data = 16'($urandom); s_last = 1'($urandom);
  endtask

  task automatic send_frame(input logic [15:0] fr[$], input bit gaps);
    sb.push_back(model(fr));
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(fr[i], i == fr.size() - 1);
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((sb.size() != 0 || m_valid) && w < 3000) begin @(negedge clk); w++; end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] fr[$];

    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_max", m_max, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fr = {16'h4f00, 16'h4900};
    send_frame(fr, 1'b1);
    wait_drain();

    hold = 1'b1;
    @(negedge clk);
    sb.push_back(model('{16'h4700, 16'h47c0, 16'hd100, 16'h5040}));
    send(16'h4700, 0); send(16'h47c0, 0); send(16'hd100, 0); send(16'h5040, 1);
    check("t2_lat0", m_valid, 0);
    @(negedge clk) check("t2_lat1", m_valid, 0);
    @(negedge clk) check("t2_lat2", m_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("t2_hold_valid", m_valid, 1);
      check("t2_hold_max", m_max, 16'h5040);
      check("t2_hold_min", m_min, 16'hd100);
      check("t2_hold_count", m_count, 4);
      check("t2_hold_s_ready", s_ready, 0);
    end
    hold = 1'b0;
    wait_drain();

    sb.push_back(model('{16'hca20}));
    send(16'hca20, 1);
    check("t3_latency", m_valid, 1);
    wait_drain();

    fr = {16'h4700, 16'h4700, 16'h4700};
    send_frame(fr, 1'b0);
    wait_drain();

    fr.delete();
    for (int i = 0; i < CMAX + 3; i++) fr.push_back(rand_val());
    fr[100] = 16'h7fff;
    fr[200] = 16'hffff;
    send_frame(fr, 1'b0);
    wait_drain();

    send(16'h4f00, 0);
    send(16'h4900, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_s_ready", s_ready, 1);
    check("t6_m_valid", m_valid, 0);
    check("t6_m_max", m_max, 0);
    check("t6_m_min", m_min, 0);
    check("t6_m_count", m_count, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fr = {16'h4900};
    send_frame(fr, 1'b0);
    wait_drain();

    for (int f = 0; f < 40; f++) begin
      fr.delete();
      repeat ($urandom_range(1, 8)) fr.push_back(rand_val());
      send_frame(fr, 1'b1);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
